reservoir_level_model: RTL and testbench
========================================

# reservoir_level_model

Behavioural plant model of the reservoir, synthesizable and cycle-accurate. It sits on the opposite side of the water-level controller's interface. It consumes the controller's valve commands (fr2, fr1, fr0, dfr) and a drain (demand) rate. It integrates net flow into a saturating water-level register and drives the debounced thermometer sensor code s[2:0] back to the controller, closing the loop for system-level simulation and FPGA demo builds.

## Interface
Parameters:
- LEVEL_W, 10: width of level accumulator
- LEVEL_MAX, 1023: saturation ceiling; must be ≤ 2^LEVEL_W−1
- TH1, 256: level at/above which s[0] asserts
- TH2, 512: level at/above which s[1] asserts; TH1 < TH2 < TH3 ≤ LEVEL_MAX
- TH3, 768: level at/above which s[2] asserts
- FR_RATE, 4: units added per cycle per asserted fr0/fr1/fr2
- DFR_RATE, 2: units added per cycle when dfr asserted
- SETTLE, 3: sensor debounce length in cycles; must be ≥ 2

Ports (reset: synchronous, active-high; clock: clk):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- fr2, fr1, fr0  in  1 each  nominal flow valves from controller
- dfr  in  1  supplemental flow valve
- drain  in  4  outflow units removed this cycle (0–15)
- load  in  1  force level to load_level this cycle
- load_level  in  LEVEL_W  value for load
- level  out  LEVEL_W  current registered water level
- s  out  3  debounced thermometer sensor code (000, 001, 011, 111 only)
- overflow  out  1  registered: level clamped at LEVEL_MAX on last update
- underflow  out  1  registered: level clamped at 0 on last update

## Operation
- inflow = FR_RATE·(fr0+fr1+fr2) + DFR_RATE·dfr; max 14 at defaults.
- Compute sum = level + inflow − drain in a signed intermediate of width LEVEL_W+2, so no wrap is possible.
- Per edge, in priority order:
  - reset: level=0, s=000, overflow=0, underflow=0, debounce candidate=000, count=0.
  - load: level=min(load_level, LEVEL_MAX); overflow=underflow=0; debounce state untouched.
  - else, if sum>LEVEL_MAX: level=LEVEL_MAX, overflow=1.
  - else, if sum<0: level=0, underflow=1.
  - else: level=sum, both flags 0.
- Flags are recomputed every cycle. They stay high for every consecutive clamped cycle.
- Inflow and drain in the same cycle net out. Simultaneous overflow and underflow are impossible.
- raw[2:0] is combinational from the registered level: raw[k] = (level ≥ TH(k+1)). It is always thermometer-coded.
- Debounce:
  - State: candidate register cand plus counter cnt, 0..SETTLE−1.
  - If raw≠cand: cand←raw, cnt←1.
  - Else if cnt<SETTLE−1: cnt increments.
  - Else: s←cand and cnt holds.
- Debounce result: s only ever takes a raw value that was stable for SETTLE consecutive cycles. Any raw change restarts qualification.
- Controller inputs are used as sampled. There are no assumptions on their legality: any 4-bit valve combination is accepted.

## Timing
- level, overflow, underflow: 1-cycle latency from inputs. A level change takes effect at edge N.
- s: if raw changes after edge N and stays stable, s shows the new code after edge N+SETTLE. Minimum 3 cycles at the default SETTLE.
- raw toggling with period < SETTLE cycles leaves s unchanged indefinitely.
- Reset mid-operation clears everything at the next edge. s=000 is valid in the cycle after reset.
- load mid-debounce: level jumps immediately; the debounce sees the new raw and requalifies per the normal rules.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold all inputs 0 for 10 cycles → level=0, s=000, overflow=underflow=0 throughout.
- Fill: fr2=fr1=fr0=dfr=1, drain=0 from level 0 →
  - level = 14 per cycle, reaching 266 after 19 edges;
  - s=001 exactly 3 edges later;
  - s=011 and s=111 at levels ≥512 and ≥768, each delayed 3 edges.
- Saturation: load 1020, then full inflow →
  - level=1023 and overflow=1 the next edge;
  - overflow stays 1 while inflow holds;
  - drops to 0 the cycle after all valves are closed with drain=5.
- Drain: load 5, valves 0, drain=15 → level=0 and underflow=1 the next edge; s decays to 000 after 3 edges.
- Glitch rejection: with s stable at 000, load 256, then load 255 on the next cycle → raw is 001 for one cycle, s stays 000.
- Equilibrium and priority:
  - fr0=1, drain=4 at level 600 → level constant 600, s=011 steady.
  - Assert reset concurrently with load → reset wins, level=0.

Source files
------------

// File: rtl/reservoir_level_model.sv
// Plant model of the reservoir: integrates valve inflow minus drain into a
// saturating level and feeds a debounced thermometer sensor code back out.
module reservoir_level_model #(
    parameter int LEVEL_W   = 10,
    parameter int LEVEL_MAX = 1023,
    parameter int TH1       = 256,
    parameter int TH2       = 512,
    parameter int TH3       = 768,
    parameter int FR_RATE   = 4,
    parameter int DFR_RATE  = 2,
    parameter int SETTLE    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fr2,
    input  logic               fr1,
    input  logic               fr0,
    input  logic               dfr,
    input  logic [3:0]         drain,
    input  logic               load,
    input  logic [LEVEL_W-1:0] load_level,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         s,
    output logic               overflow,
    output logic               underflow
);

    // Two guard bits keep level + inflow - drain from ever wrapping.
    localparam int SW = LEVEL_W + 2;
    localparam int CW = $clog2(SETTLE);

    localparam logic [LEVEL_W-1:0]  MAX_L   = LEVEL_W'(LEVEL_MAX);
    localparam logic signed [SW-1:0] MAX_S  = SW'(LEVEL_MAX);
    localparam logic signed [SW-1:0] FR_S   = SW'(FR_RATE);
    localparam logic signed [SW-1:0] DFR_S  = SW'(DFR_RATE);
    localparam logic [CW-1:0]       CNT_TOP = CW'(SETTLE - 1);

    logic signed [SW-1:0] inflow;
    logic signed [SW-1:0] sum;
    logic [2:0]           raw;
    logic [2:0]           cand;
    logic [CW-1:0]        cnt;

    // Net flow this cycle: valve contributions minus drain, added to level.
    always_comb begin
        inflow = '0;
        if (fr0) inflow = inflow + FR_S;
        if (fr1) inflow = inflow + FR_S;
        if (fr2) inflow = inflow + FR_S;
        if (dfr) inflow = inflow + DFR_S;
        sum = $signed({2'b00, level}) + inflow
            - $signed(SW'(drain));
    end

    // Raw sensor is thermometer-coded straight off the registered level.
    assign raw = {level >= LEVEL_W'(TH3),
                  level >= LEVEL_W'(TH2),
                  level >= LEVEL_W'(TH1)};

    // Level register with load override and saturation at both ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            level     <= (load_level > MAX_L) ? MAX_L : load_level;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sum > MAX_S) begin
            level     <= MAX_L;
            overflow  <= 1'b1;
            underflow <= 1'b0;
        end else if (sum[SW-1]) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b1;
        end else begin
            level     <= sum[LEVEL_W-1:0];
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end
    end

    // Debounce: a raw code must hold for SETTLE cycles before reaching s.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= 3'b000;
            cnt  <= '0;
            s    <= 3'b000;
        end else if (raw != cand) begin
            cand <= raw;
            cnt  <= CW'(1);
        end else if (cnt < CNT_TOP) begin
            cnt  <= cnt + CW'(1);
        end else begin
            s    <= cand;
        end
    end

endmodule

// File: tb/tb_reservoir_level_model.sv
// Bench for reservoir_level_model: model-driven fill run plus a table of
// hand-computed vectors for saturation, drain, glitch and priority cases.
module tb_reservoir_level_model;

    logic       clk = 1'b0;
    logic       reset;
    logic       fr2, fr1, fr0, dfr;
    logic [3:0] drain;
    logic       load;
    logic [9:0] load_level;
    logic [9:0] level;
    logic [2:0] s;
    logic       overflow, underflow;

    always #5 clk = ~clk;

    reservoir_level_model dut (
        .clk        (clk),
        .reset      (reset),
        .fr2        (fr2),
        .fr1        (fr1),
        .fr0        (fr0),
        .dfr        (dfr),
        .drain      (drain),
        .load       (load),
        .load_level (load_level),
        .level      (level),
        .s          (s),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef struct {
        logic [9:0] lvl;
        logic [2:0] s;
        logic       ov;
        logic       un;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [9:0] ll;
        logic [3:0] v;
        logic [3:0] dr;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[29];
    int   n_cmp = 0;
    int   n_bad = 0;

    int         m_lvl;
    logic [2:0] m_s;
    logic [2:0] h1, h2, h3;

    function automatic vec_t mk(logic r, logic ld, int ll, logic [3:0] v,
                                int dr, int el, logic [2:0] es,
                                logic eo, logic eu);
        vec_t t;
        t.rst   = r;
        t.ld    = ld;
        t.ll    = 10'(ll);
        t.v     = v;
        t.dr    = 4'(dr);
        t.e.lvl = 10'(el);
        t.e.s   = es;
        t.e.ov  = eo;
        t.e.un  = eu;
        return t;
    endfunction

    function automatic logic [2:0] therm(int l);
        return {l >= 768, l >= 512, l >= 256};
    endfunction

    task automatic drive(input logic r, input logic ld, input logic [9:0] ll,
                         input logic [3:0] v, input logic [3:0] dr);
        reset      = r;
        load       = ld;
        load_level = ll;
        {fr2, fr1, fr0, dfr} = v;
        drain      = dr;
    endtask

    task automatic cmp(input string tag, input int idx,
                       input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", tag, idx, act, req);
        end
    endtask

    // Reference model for the fill run; pushes the expected post-edge state.
    task automatic model_push(input logic r, input logic ld, input int ll,
                              input logic [3:0] v, input int dr);
        exp_t e;
        int   sm;
        e.ov = 1'b0;
        e.un = 1'b0;
        if (r) begin
            m_lvl = 0;
            m_s   = 3'b000;
            h1 = 3'b000; h2 = 3'b000; h3 = 3'b000;
        end else begin
            if (h1 == h2 && h2 == h3) m_s = h1;
            if (ld) begin
                m_lvl = (ll > 1023) ? 1023 : ll;
            end else begin
                sm = m_lvl + 4 * (v[3] + v[2] + v[1]) + 2 * v[0] - dr;
                if (sm > 1023) begin
                    m_lvl = 1023; e.ov = 1'b1;
                end else if (sm < 0) begin
                    m_lvl = 0; e.un = 1'b1;
                end else begin
                    m_lvl = sm;
                end
            end
            h3 = h2;
            h2 = h1;
            h1 = therm(m_lvl);
        end
        e.lvl = 10'(m_lvl);
        e.s   = m_s;
        sbq.push_back(e);
    endtask

    task automatic step(input string tag, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s[%0d]: scoreboard empty", tag, idx);
        end else begin
            e = sbq.pop_front();
            cmp({tag, ".level"}, idx, int'(level), int'(e.lvl));
            cmp({tag, ".s"}, idx, int'(s), int'(e.s));
            cmp({tag, ".ovf"}, idx, int'(overflow), int'(e.ov));
            cmp({tag, ".unf"}, idx, int'(underflow), int'(e.un));
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0,    4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[1]  = mk(0, 0, 0,    4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[2]  = mk(0, 0, 0,    4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[3]  = mk(0, 0, 0,    4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[4]  = mk(0, 1, 1020, 4'b0000, 0,  1020, 3'b000, 0, 0);
        tbl[5]  = mk(0, 0, 0,    4'b1111, 0,  1023, 3'b000, 1, 0);
        tbl[6]  = mk(0, 0, 0,    4'b1111, 0,  1023, 3'b000, 1, 0);
        tbl[7]  = mk(0, 0, 0,    4'b1111, 0,  1023, 3'b111, 1, 0);
        tbl[8]  = mk(0, 0, 0,    4'b0000, 5,  1018, 3'b111, 0, 0);
        tbl[9]  = mk(0, 1, 5,    4'b0000, 0,  5,    3'b111, 0, 0);
        tbl[10] = mk(0, 0, 0,    4'b0000, 15, 0,    3'b111, 0, 1);
        tbl[11] = mk(0, 0, 0,    4'b0000, 15, 0,    3'b111, 0, 1);
        tbl[12] = mk(0, 0, 0,    4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[13] = mk(0, 1, 256,  4'b0000, 0,  256,  3'b000, 0, 0);
        tbl[14] = mk(0, 1, 255,  4'b0000, 0,  255,  3'b000, 0, 0);
        tbl[15] = mk(0, 0, 0,    4'b0000, 0,  255,  3'b000, 0, 0);
        tbl[16] = mk(0, 0, 0,    4'b0000, 0,  255,  3'b000, 0, 0);
        tbl[17] = mk(0, 0, 0,    4'b0000, 0,  255,  3'b000, 0, 0);
        tbl[18] = mk(0, 1, 600,  4'b0000, 0,  600,  3'b000, 0, 0);
        tbl[19] = mk(0, 0, 0,    4'b0010, 4,  600,  3'b000, 0, 0);
        tbl[20] = mk(0, 0, 0,    4'b0010, 4,  600,  3'b000, 0, 0);
        tbl[21] = mk(0, 0, 0,    4'b0010, 4,  600,  3'b011, 0, 0);
        tbl[22] = mk(0, 0, 0,    4'b0010, 4,  600,  3'b011, 0, 0);
        tbl[23] = mk(1, 1, 100,  4'b0000, 0,  0,    3'b000, 0, 0);
        tbl[24] = mk(0, 1, 1023, 4'b0000, 0,  1023, 3'b000, 0, 0);
        tbl[25] = mk(0, 0, 0,    4'b0100, 0,  1023, 3'b000, 1, 0);
        tbl[26] = mk(0, 0, 0,    4'b0000, 15, 1008, 3'b000, 0, 0);
        tbl[27] = mk(0, 0, 0,    4'b1100, 15, 1001, 3'b111, 0, 0);
        tbl[28] = mk(0, 0, 0,    4'b0001, 2,  1001, 3'b111, 0, 0);

        // Reset, idle hold, then full-inflow fill against the model.
        drive(1, 0, 0, 4'b0000, 0);
        model_push(1, 0, 0, 4'b0000, 0);
        step("rst", 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 4'b0000, 0);
            model_push(0, 0, 0, 4'b0000, 0);
            step("idle", i);
        end
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, 4'b1111, 0);
            model_push(0, 0, 0, 4'b1111, 0);
            step("fill", k);
            if (k == 19) cmp("fill266", k, int'(level), 266);
            if (k == 21) cmp("fill_s_pre", k, int'(s), 0);
            if (k == 22) cmp("fill_s_001", k, int'(s), 1);
            if (k == 39) cmp("fill_s_pre2", k, int'(s), 1);
            if (k == 40) cmp("fill_s_011", k, int'(s), 3);
            if (k == 58) cmp("fill_s_111", k, int'(s), 7);
        end

        // Hand-computed corner-case table.
        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].ll, tbl[i].v, tbl[i].dr);
            sbq.push_back(tbl[i].e);
            step("vec", i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
